// File: rtl/issue_ctrl_pkg.sv
// Shared constants and FSM encodings for the decode-stage issue controller.
package issue_ctrl_pkg;

  localparam int unsigned REG_NUM   = 32;
  localparam int unsigned REG_AW    = 5;
  localparam int unsigned CNT_W     = 2;
  localparam int unsigned MULTI_LAT = 4;
  localparam int unsigned LAT_W     = $clog2(MULTI_LAT);

  localparam logic [REG_AW-1:0] ZERO_REG = '0;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/issue_scoreboard.sv
// Per-register in-flight write counters; register 0 is never tracked.
module issue_scoreboard
  import issue_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_i,
  input  logic [REG_AW-1:0] inc_addr_i,
  input  logic              dec_i,
  input  logic [REG_AW-1:0] dec_addr_i,
  input  logic [REG_AW-1:0] rd1_addr_i,
  input  logic [REG_AW-1:0] rd2_addr_i,
  output logic [CNT_W-1:0]  rd1_cnt_o,
  output logic [CNT_W-1:0]  rd2_cnt_o,
  output logic              full_o
);

  logic [CNT_W-1:0] cnt_q [REG_NUM];
  logic [CNT_W-1:0] cnt_d [REG_NUM];
  logic [REG_NUM-1:0] inc_hit;
  logic [REG_NUM-1:0] dec_hit;

  // Next counts: +1 on issue, -1 on retire, unchanged when both hit the same register.
  always_comb begin
    for (int unsigned r = 0; r < REG_NUM; r++) begin
      cnt_d[r]   = cnt_q[r];
      inc_hit[r] = inc_i && (inc_addr_i == REG_AW'(r)) && (r != 0) && (cnt_q[r] != CNT_MAX);
      dec_hit[r] = dec_i && (dec_addr_i == REG_AW'(r)) && (r != 0) && (cnt_q[r] != '0);
      if (inc_hit[r] && !dec_hit[r]) begin
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (dec_hit[r] && !inc_hit[r]) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
  end

  // Counter state, cleared by reset.
  always_ff @(posedge clk) begin
    for (int unsigned r = 0; r < REG_NUM; r++) begin
      if (rst) begin
        cnt_q[r] <= '0;
      end else begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  assign rd1_cnt_o = cnt_q[rd1_addr_i];
  assign rd2_cnt_o = cnt_q[rd2_addr_i];
  assign full_o    = (cnt_q[inc_addr_i] == CNT_MAX);

endmodule

// File: rtl/issue_ctrl.sv
// Decode-stage issue/stall controller: register scoreboard plus multi-cycle busy FSM.
// Optional feature macro: ISSUE_CTRL_FORWARD_EN (only loads are tracked, retired at MEM).
module issue_ctrl
  import issue_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_re1,
  input  logic [REG_AW-1:0] id_raddr1,
  input  logic              id_re2,
  input  logic [REG_AW-1:0] id_raddr2,
  input  logic              id_we,
  input  logic [REG_AW-1:0] id_waddr,
  input  logic              id_is_load,
  input  logic              id_is_multi,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_waddr,
  input  logic              mem_ld_done,
  input  logic [REG_AW-1:0] mem_ld_addr,
  output logic              issue,
  output logic              stall,
  output logic              busy
);

  state_e             state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               busy_q, busy_d;

  logic               trk_we;
  logic               sb_dec;
  logic [REG_AW-1:0]  sb_dec_addr;
  logic [CNT_W-1:0]   rd1_cnt, rd2_cnt;
  logic               sb_full;
  logic               hazard, full, block;

`ifdef ISSUE_CTRL_FORWARD_EN
  // Forwarding covers ALU results; only load results must be waited for.
  assign trk_we      = id_we & id_is_load;
  assign sb_dec      = mem_ld_done;
  assign sb_dec_addr = mem_ld_addr;
  logic unused_wb;
  assign unused_wb   = ^{wb_we, wb_waddr};
`else
  // No forwarding: every write is outstanding until write-back.
  assign trk_we      = id_we;
  assign sb_dec      = wb_we;
  assign sb_dec_addr = wb_waddr;
  logic unused_mem;
  assign unused_mem  = ^{mem_ld_done, mem_ld_addr};
`endif

  issue_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (issue & trk_we),
    .inc_addr_i (id_waddr),
    .dec_i      (sb_dec),
    .dec_addr_i (sb_dec_addr),
    .rd1_addr_i (id_raddr1),
    .rd2_addr_i (id_raddr2),
    .rd1_cnt_o  (rd1_cnt),
    .rd2_cnt_o  (rd2_cnt),
    .full_o     (sb_full)
  );

  // Issue decision from current-cycle counts; reset suppresses both outputs.
  always_comb begin
    hazard = (id_re1 && (id_raddr1 != ZERO_REG) && (rd1_cnt != '0)) ||
             (id_re2 && (id_raddr2 != ZERO_REG) && (rd2_cnt != '0));
    full   = trk_we && (id_waddr != ZERO_REG) && sb_full;
    block  = hazard || full || busy_q;
    stall  = !rst && id_valid && block;
    issue  = !rst && id_valid && !block;
  end

  // Busy FSM next state: occupy EX for MULTI_LAT cycles after a multi-cycle issue.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (issue && id_is_multi) begin
          state_d = ST_BUSY;
          lat_d   = LAT_W'(MULTI_LAT - 1);
        end
      end
      ST_BUSY: begin
        if (lat_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_BUSY);
  end

  // FSM and busy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule
